reg_file: RTL and testbench

Decode-stage integer register file for the 5-stage RISC-V pipeline. It supplies `RD1D` and `RD2D` to the decode-to-execute pipeline register and accepts the writeback-stage result. It provides 32 architectural registers, two asynchronous read ports and one synchronous write port, with x0 hardwired to zero. Optional same-cycle write-to-read bypass removes the need for a split-phase (falling-edge) write.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/reg_file_rdport.sv | 42 ++++
 rtl/reg_file.sv | 76 +++++++
 tb/tb_reg_file.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V integer datapath: default widths,
// architectural register indices and common word/index types.
package riscv_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  // Architectural register indices with special meaning in the register file.
  localparam int REG_ZERO = 0;
  localparam int REG_A0   = 10;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] regidx_t;

endpackage : riscv_pkg

// File: rtl/reg_file_rdport.sv
// One asynchronous read port of the integer register file. Applies the x0
// rule and, when REGFILE_BYPASS_EN is defined, forwards the writeback data
// to the read port on an index match in the same cycle.
module reg_file_rdport #(
  parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = riscv_pkg::ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] rs_idx,
  input  logic [DATA_WIDTH-1:0] entry,
  input  logic [ADDR_WIDTH-1:0] rd_w,
  input  logic [DATA_WIDTH-1:0] result_w,
  input  logic                  reg_write_w,
  output logic [DATA_WIDTH-1:0] rd_data
);
  import riscv_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = ADDR_WIDTH'(REG_ZERO);

`ifdef REGFILE_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = reg_write_w && (rd_w == rs_idx) && (rd_w != IDX_ZERO);
`else
  // Write-port inputs are only consumed by the bypass path.
  logic unused_write_port;
  assign unused_write_port = ^{rd_w, result_w, reg_write_w};
`endif

  // Select read data: array entry, optionally bypassed, x0 forced to zero last.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    rd_data = entry;
`ifdef REGFILE_BYPASS_EN
    if (bypass_hit) begin
      rd_data = result_w;
    end
`endif
    if (rs_idx == IDX_ZERO) begin
      rd_data = '0;
    end
  end

endmodule : reg_file_rdport

// File: rtl/reg_file.sv
// Decode-stage integer register file: 32 x 32-bit, two asynchronous read
// ports, one synchronous write port, x0 hardwired to zero, synchronous
// active-high reset clearing every entry. Optional same-cycle write-to-read
// bypass is enabled by defining REGFILE_BYPASS_EN.
module reg_file #(
  parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = riscv_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Rs1D,
  input  logic [ADDR_WIDTH-1:0] Rs2D,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic [DATA_WIDTH-1:0] ResultW,
  input  logic                  RegWriteW,
  output logic [DATA_WIDTH-1:0] RD1D,
  output logic [DATA_WIDTH-1:0] RD2D,
  output logic [DATA_WIDTH-1:0] a0
);
  import riscv_pkg::*;

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = ADDR_WIDTH'(REG_ZERO);
  localparam logic [ADDR_WIDTH-1:0] IDX_A0   = ADDR_WIDTH'(REG_A0);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  // Next array state: apply the writeback write unless it targets x0.
  always_comb begin
    regs_d = regs_q;
    if (RegWriteW && (RdW != IDX_ZERO)) begin
      regs_d[RdW] = ResultW;
    end
    regs_d[IDX_ZERO] = '0;
  end

  // Array state register; reset wins over a write on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: the whole array is reset here because software relies on every register reading 0 after reset; this rules out a RAM macro.
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // a0 always shows the stored x10 value; it never sees the bypass.
  assign a0 = regs_q[IDX_A0];

  reg_file_rdport #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rdport1 (
    .rs_idx      (Rs1D),
    .entry       (regs_q[Rs1D]),
    .rd_w        (RdW),
    .result_w    (ResultW),
    .reg_write_w (RegWriteW),
    .rd_data     (RD1D)
  );

  reg_file_rdport #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rdport2 (
    .rs_idx      (Rs2D),
    .entry       (regs_q[Rs2D]),
    .rd_w        (RdW),
    .result_w    (ResultW),
    .reg_write_w (RegWriteW),
    .rd_data     (RD2D)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file. Expected read values are pushed to a
// scoreboard queue when inputs are driven, then popped and compared on the
// falling edge before the next rising edge. Expectations follow
// REGFILE_BYPASS_EN when it is defined for the build.
module tb_reg_file;
  import riscv_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam int SEL_RD1 = 0;
  localparam int SEL_RD2 = 1;
  localparam int SEL_A0  = 2;

  logic    clk = 1'b0;
  logic    rst;
  regidx_t Rs1D, Rs2D, RdW;
  word_t   ResultW;
  logic    RegWriteW;
  word_t   RD1D, RD2D, a0;

  int n_cmp  = 0;
  int n_fail = 0;

  word_t exp_q [$];
  int    sel_q [$];
  string tag_q [$];

  reg_file dut (
    .clk       (clk),
    .rst       (rst),
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .RdW       (RdW),
    .ResultW   (ResultW),
    .RegWriteW (RegWriteW),
    .RD1D      (RD1D),
    .RD2D      (RD2D),
    .a0        (a0)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input int sel, input word_t value, input string tag);
    sel_q.push_back(sel);
    exp_q.push_back(value);
    tag_q.push_back(tag);
  endtask

  // Compare every queued expectation against the current outputs.
  task automatic check();
    word_t obs, exp_v;
    int    sel;
    string tag;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      sel   = sel_q.pop_front();
      tag   = tag_q.pop_front();
      case (sel)
        SEL_RD1: obs = RD1D;
        SEL_RD2: obs = RD2D;
        default: obs = a0;
      endcase
      n_cmp++;
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  // Sample outputs on the falling edge, then advance past the rising edge.
  task automatic cycle();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic we, input int rd, input word_t data,
                       input int rs1, input int rs2);
    rst       = r;
    RegWriteW = we;
    RdW       = regidx_t'(rd);
    ResultW   = data;
    Rs1D      = regidx_t'(rs1);
    Rs2D      = regidx_t'(rs2);
  endtask

  initial begin
    drive(1'b1, 1'b0, 0, '0, 0, 0);
    cycle();

    // Reset state.
    drive(1'b0, 1'b0, 0, '0, 5, 10);
    push_exp(SEL_RD1, 32'h0, "rst_state_x5");
    push_exp(SEL_RD2, 32'h0, "rst_state_x10");
    push_exp(SEL_A0,  32'h0, "rst_state_a0");
    cycle();

    // Write x5, confirm it landed, then reset clears it.
    drive(1'b0, 1'b1, 5, 32'h1234, 0, 0);
    push_exp(SEL_RD1, 32'h0, "x0_during_write");
    cycle();
    drive(1'b0, 1'b0, 0, '0, 5, 0);
    push_exp(SEL_RD1, 32'h1234, "x5_written");
    cycle();
    drive(1'b1, 1'b0, 0, '0, 5, 10);
    cycle();
    drive(1'b0, 1'b0, 0, '0, 5, 10);
    push_exp(SEL_RD1, 32'h0, "x5_after_rst");
    push_exp(SEL_A0,  32'h0, "a0_after_rst");
    cycle();

    // Basic write/read of x10.
    drive(1'b0, 1'b1, 10, 32'hDEADBEEF, 0, 0);
    cycle();
    drive(1'b0, 1'b0, 0, '0, 10, 10);
    push_exp(SEL_RD1, 32'hDEADBEEF, "x10_rd1");
    push_exp(SEL_RD2, 32'hDEADBEEF, "x10_rd2");
    push_exp(SEL_A0,  32'hDEADBEEF, "x10_a0");
    cycle();

    // x0 protection: no bypass, no state change.
    drive(1'b0, 1'b1, 0, 32'hFFFFFFFF, 0, 0);
    push_exp(SEL_RD1, 32'h0, "x0_write_same");
    push_exp(SEL_RD2, 32'h0, "x0_write_same_rd2");
    cycle();
    drive(1'b0, 1'b0, 0, '0, 0, 0);
    push_exp(SEL_RD1, 32'h0, "x0_write_next");
    cycle();

    // Same-cycle read-after-write on x7.
    drive(1'b0, 1'b1, 7, 32'h11, 0, 0);
    cycle();
    drive(1'b0, 1'b1, 7, 32'h22, 7, 7);
    push_exp(SEL_RD1, BYPASS ? 32'h22 : 32'h11, "raw_x7_rd1_n");
    push_exp(SEL_RD2, BYPASS ? 32'h22 : 32'h11, "raw_x7_rd2_n");
    push_exp(SEL_A0,  32'hDEADBEEF, "raw_x7_a0");
    cycle();
    drive(1'b0, 1'b0, 0, '0, 7, 7);
    push_exp(SEL_RD1, 32'h22, "raw_x7_rd1_n1");
    push_exp(SEL_RD2, 32'h22, "raw_x7_rd2_n1");
    cycle();

    // a0 never bypasses: writing x10 shows the old value until the edge.
    drive(1'b0, 1'b1, 10, 32'hCAFEF00D, 10, 0);
    push_exp(SEL_RD1, BYPASS ? 32'hCAFEF00D : 32'hDEADBEEF, "raw_x10_rd1");
    push_exp(SEL_A0,  32'hDEADBEEF, "raw_x10_a0_old");
    cycle();
    drive(1'b0, 1'b0, 0, '0, 0, 0);
    push_exp(SEL_A0, 32'hCAFEF00D, "raw_x10_a0_new");
    cycle();

    // Back-to-back writes to the same index: last edge wins.
    drive(1'b0, 1'b1, 9, 32'hAAAA, 0, 0);
    cycle();
    drive(1'b0, 1'b1, 9, 32'hBBBB, 0, 0);
    cycle();
    drive(1'b0, 1'b0, 0, '0, 9, 0);
    push_exp(SEL_RD1, 32'hBBBB, "b2b_x9");
    cycle();

    // Reset collides with a write: reset wins.
    drive(1'b1, 1'b1, 3, 32'h55, 0, 0);
    cycle();
    drive(1'b0, 1'b0, 0, '0, 3, 7);
    push_exp(SEL_RD1, 32'h0, "rst_collide_x3");
    push_exp(SEL_RD2, 32'h0, "rst_collide_x7");
    push_exp(SEL_A0,  32'h0, "rst_collide_a0");
    cycle();

    // Sweep: x1..x31 = 3*i; the attempted x0 write must not stick.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, i, (i == 0) ? 32'hFFFF : word_t'(3 * i), 0, 0);
      cycle();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 0, '0, i, 31 - i);
      push_exp(SEL_RD1, word_t'(3 * i), $sformatf("sweep_rd1_x%0d", i));
      push_exp(SEL_RD2, word_t'(3 * (31 - i)), $sformatf("sweep_rd2_x%0d", 31 - i));
      cycle();
    end
    drive(1'b0, 1'b0, 0, '0, 0, 0);
    push_exp(SEL_A0, 32'd30, "sweep_a0");
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_reg_file
